// File: rtl/muller_pkg.sv
// muller_pkg: C-element rule, reset constant and occupancy-width helper shared by the Muller pipeline
package muller_pkg;
    localparam logic C_RST = 1'b0;
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction
    function automatic logic c_next(input logic a, input logic b, input logic q);
        return (a == b) ? a : q;
    endfunction
endpackage

// File: rtl/muller_c_stage.sv
// muller_c_stage: one clocked C-element with a data register loaded whenever the element fires
// ports: i_clk/i_rst (async active-high), i_a predecessor state, i_b inverted successor state,
//        i_d incoming data, o_c C state, o_d held data
module muller_c_stage
    import muller_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_a,
    input  logic             i_b,
    input  logic [WIDTH-1:0] i_d,
    output logic             o_c,
    output logic [WIDTH-1:0] o_d
);
    logic             r_c;
    logic [WIDTH-1:0] r_d;
    logic             w_c_nxt;
    assign w_c_nxt = c_next(i_a, i_b, r_c);
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_c <= C_RST;
            r_d <= '0;
        end else begin
            r_c <= w_c_nxt;
            if (w_c_nxt != r_c) r_d <= i_d;
        end
    end
    assign o_c = r_c;
    assign o_d = r_d;
endmodule

// File: rtl/muller_c_pipeline.sv
// muller_c_pipeline: DEPTH-stage 2-phase bundled-data micropipeline with input synchronisers and occupancy
// ports: wb_clk_i sampling clock, wb_rst_i async active-high reset,
//        in_req/in_data/in_ack sender side, out_req/out_data/out_ack receiver side,
//        occupancy tokens held, c_state all C states,
//        proto_err sticky protocol-violation flag (only when MULLER_PROTO_CHECK_EN is defined)
module muller_c_pipeline
    import muller_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    localparam int OCC_W      = occ_w(DEPTH)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             in_req,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ack,
    output logic             out_req,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ack,
    output logic [OCC_W-1:0] occupancy,
    output logic [DEPTH-1:0] c_state
`ifdef MULLER_PROTO_CHECK_EN
    ,
    output logic             proto_err
`endif
);
    logic [SYNC_STAGES-1:0] r_req_sync, r_ack_sync;
    logic [SYNC_STAGES:0]   w_req_chain, w_ack_chain;
    logic                   w_req_s, w_ack_s;
    // chain bit 0 is the raw input, top bit is the synchronised value
    assign w_req_chain = {r_req_sync, in_req};
    assign w_ack_chain = {r_ack_sync, out_ack};
    assign w_req_s     = w_req_chain[SYNC_STAGES];
    assign w_ack_s     = w_ack_chain[SYNC_STAGES];
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_req_sync <= '0;
            r_ack_sync <= '0;
        end else begin
            r_req_sync <= w_req_chain[SYNC_STAGES-1:0];
            r_ack_sync <= w_ack_chain[SYNC_STAGES-1:0];
        end
    end
    logic [DEPTH-1:0]            w_c, w_prev, w_next, w_held;
    logic [DEPTH-1:0][WIDTH-1:0] w_d, w_din;
    // neighbour views: predecessor of stage 0 is req_s, successor of the last stage is ack_s
    assign w_prev = {w_c[DEPTH-2:0], w_req_s};
    assign w_next = {w_ack_s, w_c[DEPTH-1:1]};
    assign w_din  = {w_d[DEPTH-2:0], in_data};
    assign w_held = w_c ^ w_next;
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        muller_c_stage #(.WIDTH(WIDTH)) u_stage (
            .i_clk (wb_clk_i),
            .i_rst (wb_rst_i),
            .i_a   (w_prev[g]),
            .i_b   (~w_next[g]),
            .i_d   (w_din[g]),
            .o_c   (w_c[g]),
            .o_d   (w_d[g])
        );
    end
    assign in_ack    = w_c[0];
    assign out_req   = w_c[DEPTH-1];
    assign out_data  = w_d[DEPTH-1];
    assign c_state   = w_c;
    assign occupancy = OCC_W'($countones(w_held));
`ifdef MULLER_PROTO_CHECK_EN
    logic r_proto_err;
    logic w_req_bad, w_ack_bad;
    // req_s about to move while the previous token is still unacknowledged
    assign w_req_bad = (w_req_chain[SYNC_STAGES-1] != w_req_s) && (w_req_s != w_c[0]);
    // ack_s about to move while the last stage offers nothing
    assign w_ack_bad = (w_ack_chain[SYNC_STAGES-1] != w_ack_s) && (w_c[DEPTH-1] == w_ack_s);
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_proto_err <= 1'b0;
        else if (w_req_bad || w_ack_bad) r_proto_err <= 1'b1;
    end
    assign proto_err = r_proto_err;
`endif
endmodule

// File: tb/tb_muller_c_pipeline.sv
// tb_muller_c_pipeline: table-driven latency vectors, fill/backpressure, randomized streaming and reset checks
module tb_muller_c_pipeline;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_req, out_ack;
    logic [3:0] in_data;
    logic       in_ack, out_req;
    logic [3:0] out_data;
    logic [2:0] occupancy;
    logic [3:0] c_state;
`ifdef MULLER_PROTO_CHECK_EN
    logic       proto_err;
`endif
    int n_tests = 0;
    int n_fail  = 0;

    muller_c_pipeline #(.WIDTH(4), .DEPTH(4), .SYNC_STAGES(2)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .in_req    (in_req),
        .in_data   (in_data),
        .in_ack    (in_ack),
        .out_req   (out_req),
        .out_data  (out_data),
        .out_ack   (out_ack),
        .occupancy (occupancy),
        .c_state   (c_state)
`ifdef MULLER_PROTO_CHECK_EN
        ,
        .proto_err (proto_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        int         lat_ack;
        int         lat_req;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ack(input int budget);
        for (int i = 0; i < budget && in_ack != in_req; i++) adv(1);
    endtask

    task automatic wait_out(input int budget);
        for (int i = 0; i < budget && out_req == out_ack; i++) adv(1);
    endtask

    // one token into an empty pipeline, measuring both handshake latencies, then drained
    task automatic send_one(input logic [3:0] d, input int exp_ack, input int exp_req);
        int ta = -1;
        int tr = -1;
        in_data = d;
        in_req  = !in_req;
        for (int c = 1; c <= 20 && tr < 0; c++) begin
            adv(1);
            if (ta < 0 && in_ack == in_req) ta = c;
            if (out_req != out_ack) tr = c;
        end
        chk("lat_in_ack", ta, exp_ack);
        chk("lat_out_req", tr, exp_req);
        chk("single_data", out_data, d);
        chk("single_occ", occupancy, 1);
        out_ack = !out_ack;
        adv(1);
        chk("single_occ_hold", occupancy, 1);
        adv(1);
        chk("single_occ_drain", occupancy, 0);
    endtask

    // sender/receiver act randomly; tokens conserved, order preserved, occupancy = accepted - released
    task automatic stream(input int n_tok, input int p_send, input int p_recv);
        logic [3:0] q[$];
        int         ack_t[$];
        int         sent = 0, got = 0, n_acc = 0, n_rel = 0, peak = 0;
        logic       prev_ack = in_ack;
        logic [3:0] exp_d;
        for (int cy = 0; got < n_tok && cy < 3000; cy++) begin
            if (in_ack != prev_ack) begin
                n_acc++;
                prev_ack = in_ack;
            end
            while (ack_t.size() > 0 && ack_t[0] + 2 <= cy) begin
                void'(ack_t.pop_front());
                n_rel++;
            end
            chk("stream_occ", occupancy, n_acc - n_rel);
            if (int'(occupancy) > peak) peak = int'(occupancy);
            if (out_req != out_ack && $urandom_range(99) < p_recv) begin
                exp_d = (q.size() > 0) ? q.pop_front() : 4'bx;
                chk("stream_data", out_data, exp_d);
                got++;
                out_ack = !out_ack;
                ack_t.push_back(cy);
            end
            if (in_ack == in_req && sent < n_tok && $urandom_range(99) < p_send) begin
                in_data = 4'($urandom);
                q.push_back(in_data);
                in_req = !in_req;
                sent++;
            end
            adv(1);
        end
        chk("stream_count", got, n_tok);
        chk("stream_peak_le_depth", peak <= 4, 1);
        adv(3);
        chk("stream_empty", occupancy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[4];
        tbl[0] = '{4'hA, 3, 6};
        tbl[1] = '{4'h5, 3, 6};
        tbl[2] = '{4'hF, 3, 6};
        tbl[3] = '{4'h0, 3, 6};
        rst = 1'b1; in_req = 1'b0; out_ack = 1'b0; in_data = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_in_ack", in_ack, 0);
        chk("rst_out_req", out_req, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_c_state", c_state, 0);
        rst = 1'b0;
        adv(1);
        for (int i = 0; i < 4; i++) send_one(tbl[i].d, tbl[i].lat_ack, tbl[i].lat_req);

        for (int k = 1; k <= 4; k++) begin
            in_data = 4'(k);
            in_req  = !in_req;
            wait_ack(30);
            chk("fill_ack", in_ack, in_req);
        end
        adv(4);
        chk("fill_occ", occupancy, 4);
        in_data = 4'h5;
        in_req  = !in_req;
        adv(15);
        chk("fill_stall", in_ack, !in_req);
        chk("fill_occ_stall", occupancy, 4);
        for (int k = 1; k <= 5; k++) begin
            wait_out(30);
            chk("fill_out_data", out_data, k);
            out_ack = !out_ack;
            if (k == 1) begin
                wait_ack(30);
                chk("fill_5th_accept", in_ack, in_req);
            end
        end
        adv(4);
        chk("fill_drained", occupancy, 0);

        stream(20, 100, 100);
        stream(60, 50, 35);

        for (int k = 0; k < 3; k++) begin
            in_data = 4'(k + 7);
            in_req  = !in_req;
            wait_ack(30);
        end
        adv(4);
        chk("mid_occ3", occupancy, 3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_occ", occupancy, 0);
        chk("async_rst_c_state", c_state, 0);
        chk("async_rst_out_req", out_req, 0);
        chk("async_rst_out_data", out_data, 0);
        @(negedge clk);
        in_req = 1'b0; out_ack = 1'b0;
        adv(1);
        rst = 1'b0;
        adv(1);
        send_one(4'h6, 3, 6);

`ifdef MULLER_PROTO_CHECK_EN
        chk("proto_clean", proto_err, 0);
        in_req = !in_req;
        adv(1);
        in_req = !in_req;
        adv(3);
        chk("proto_set", proto_err, 1);
        adv(10);
        chk("proto_sticky", proto_err, 1);
        rst = 1'b1;
        #1;
        chk("proto_rst", proto_err, 0);
        @(negedge clk);
        rst = 1'b0;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
